// File: rtl/std_muladd_seq.sv
// Shift-add unsigned multiply-add: {out_hi,out} = left*right + addend, one multiplier bit per RUN cycle.
// Latency is width+1 edges from go to done (fewer with STD_MULADD_EARLY_EXIT_EN); hold go until done, dropping it aborts.
module std_muladd_seq #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic [width-1:0] left,
    input  logic [width-1:0] right,
    input  logic [width-1:0] addend,
    output logic [width-1:0] out,
    output logic [width-1:0] out_hi,
    output logic             done
);
    localparam int CW = $clog2(width + 1);
    localparam logic [CW-1:0] LAST = CW'(width - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [2*width-1:0]   acc;
    logic [2*width-1:0]   mcand;
    logic [2*width-1:0]   sum;
    logic [width-1:0]     mplier;
    logic [CW-1:0]        cnt;
    logic                 last;

    // sum already contains this cycle's partial product, so it is the final value on the last step
    always_comb begin
        sum = acc + (mplier[0] ? mcand : '0);
`ifdef STD_MULADD_EARLY_EXIT_EN
        last = (cnt == LAST) || (mplier[width-1:1] == '0);
`else
        last = (cnt == LAST);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (go) state_nxt = RUN;
            end
            RUN: begin
                if (!go)       state_nxt = IDLE;
                else if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            out    <= '0;
            out_hi <= '0;
        end else begin
            // results persist only while the caller keeps go asserted
            if (!go) begin
                out    <= '0;
                out_hi <= '0;
            end
            case (state)
                IDLE: begin
                    if (go) begin
                        mcand  <= {{width{1'b0}}, left};
                        mplier <= right;
                        acc    <= {{width{1'b0}}, addend};
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    if (go) begin
                        acc    <= sum;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                        if (last) begin
                            {out_hi, out} <= sum;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
